arq_symbol_tx: RTL and testbench

Parametrised frame transmitter for the communication-experiment datapath: generates pseudo-random symbols of SYM_W bits from an LFSR, groups them into frames of FRAME_LEN symbols and emits one symbol per clock. Each frame is buffered so it can be replayed when the downstream checker flags `has_error` (stop-and-wait ARQ, bounded by MAX_RETRY). It is the successor of the fixed 2-bit transmitter: it generalises symbol width and frame length and adds retransmission, pause and drop reporting.

---
 rtl/arq_symbol_tx_pkg.sv | 32 +++
 rtl/arq_symbol_tx_if.sv | 39 +++
 rtl/arq_symbol_tx_lfsr16.sv | 39 +++
 rtl/arq_symbol_tx.sv | 214 +++++++++++++++++++++
 tb/tb_arq_symbol_tx.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arq_symbol_tx_pkg.sv
// ---------------------------------------------------------------------------
// arq_symbol_tx_pkg
// Shared definitions for the ARQ symbol transmitter:
//   - tx_state_e    : transmitter FSM state encoding
//   - LFSR_TAP_MASK : feedback taps of x^16+x^14+x^13+x^11+1 (right-shift form)
//   - DEFAULT_SEED  : power-on LFSR load value
//   - lfsr_next()   : one Fibonacci step, new MSB is the parity of the taps
//   - retry_w()     : width of the retry counter (at least one bit)
// ---------------------------------------------------------------------------
package arq_symbol_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_ACK    = 2'd2,
    ST_RESEND = 2'd3
  } tx_state_e;

  // Taps at bits 0, 2, 3 and 5 feed the new MSB when shifting right.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAP_MASK), cur[15:1]};
  endfunction

  // MAX_RETRY = 0 still needs a one-bit counter port.
  function automatic int retry_w(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/arq_symbol_tx_if.sv
// ---------------------------------------------------------------------------
// arq_symbol_tx_if
// Bundles the control inputs and the symbol/frame outputs of arq_symbol_tx.
//   init_tab    : sync reinitialise pulse
//   IsTransmit  : transmit enable / pause
//   has_error   : frame verdict from the downstream checker
//   sym_out, sym_valid, frame_start, frame_end : symbol stream
//   retry_cnt, frame_id, frame_ok, frame_drop  : frame status
// master: the transmitter side; slave: the driver/checker side.
// ---------------------------------------------------------------------------
interface arq_symbol_tx_if #(
  parameter int SYM_W = 2,
  parameter int FID_W = 8,
  parameter int RC_W  = 2
);
  logic             init_tab;
  logic             IsTransmit;
  logic             has_error;
  logic [SYM_W-1:0] sym_out;
  logic             sym_valid;
  logic             frame_start;
  logic             frame_end;
  logic [RC_W-1:0]  retry_cnt;
  logic [FID_W-1:0] frame_id;
  logic             frame_ok;
  logic             frame_drop;

  modport master (
    input  init_tab, IsTransmit, has_error,
    output sym_out, sym_valid, frame_start, frame_end,
           retry_cnt, frame_id, frame_ok, frame_drop
  );

  modport slave (
    output init_tab, IsTransmit, has_error,
    input  sym_out, sym_valid, frame_start, frame_end,
           retry_cnt, frame_id, frame_ok, frame_drop
  );
endinterface

// File: rtl/arq_symbol_tx_lfsr16.sv
// ---------------------------------------------------------------------------
// arq_symbol_tx_lfsr16
// 16-bit Fibonacci LFSR symbol source.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   load       : sync reload with SEED (wins over step)
//   step       : advance one step
//   sym        : low SYM_W bits of the current state
// ---------------------------------------------------------------------------
module arq_symbol_tx_lfsr16
  import arq_symbol_tx_pkg::*;
#(
  parameter int          SYM_W = 2,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [SYM_W-1:0] sym
);

  logic [15:0] lfsr_r;

  // LFSR state: reload has priority over stepping, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= SEED;
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign sym = lfsr_r[SYM_W-1:0];

endmodule

// File: rtl/arq_symbol_tx.sv
// ---------------------------------------------------------------------------
// arq_symbol_tx
// Stop-and-wait ARQ frame transmitter. Emits FRAME_LEN LFSR symbols per
// frame, one per enabled cycle, buffers them, and replays the buffer when
// the checker reports has_error in the ACK cycle (up to MAX_RETRY times).
//   sys_clk : rising-edge clock
//   reset   : async active-low reset
//   bus     : arq_symbol_tx_if.master (controls in, symbol/status out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module arq_symbol_tx
  import arq_symbol_tx_pkg::*;
#(
  parameter int          SYM_W     = 2,
  parameter int          FRAME_LEN = 8,
  parameter int          MAX_RETRY = 3,
  parameter logic [15:0] SEED      = DEFAULT_SEED,
  parameter int          FID_W     = 8
) (
  input logic            sys_clk,
  input logic            reset,
  arq_symbol_tx_if.master bus
);

  localparam int RC_W  = retry_w(MAX_RETRY);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] FIRST_IDX   = IDX_W'(0);
  localparam logic [IDX_W-1:0] SECOND_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [RC_W-1:0]  MAX_RETRY_C = RC_W'(MAX_RETRY);

  tx_state_e        state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [SYM_W-1:0] frame_buf_r [FRAME_LEN];

  logic [SYM_W-1:0] lfsr_sym_s;
  logic             lfsr_load_s, lfsr_step_s, buf_we_s;
  logic             last_s, can_retry_s;

  logic [SYM_W-1:0] sym_r, sym_s;
  logic             valid_r, valid_s;
  logic             start_r, start_s;
  logic             end_r, end_s;
  logic             ok_r, ok_s;
  logic             drop_r, drop_s;
  logic [RC_W-1:0]  retry_r, retry_s;
  logic [FID_W-1:0] fid_r, fid_s;

  assign last_s      = (idx_r == LAST_IDX);
  assign can_retry_s = (retry_r < MAX_RETRY_C);

  arq_symbol_tx_lfsr16 #(
    .SYM_W (SYM_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (sys_clk),
    .rst_n (reset),
    .load  (lfsr_load_s),
    .step  (lfsr_step_s),
    .sym   (lfsr_sym_s)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; init_tab overrides every transition.
  always_comb begin
    state_s = state_r;
    if (bus.init_tab) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.IsTransmit) state_s = ST_SEND;
          else                state_s = ST_IDLE;
        end
        ST_SEND, ST_RESEND: begin
          if (bus.IsTransmit && last_s) state_s = ST_ACK;
          else                          state_s = state_r;
        end
        ST_ACK: begin
          if (!bus.has_error)   state_s = ST_IDLE;
          else if (can_retry_s) state_s = ST_RESEND;
          else                  state_s = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // FSM output logic: next values of the registered outputs and datapath controls.
  always_comb begin
    idx_s       = idx_r;
    sym_s       = sym_r;
    valid_s     = 1'b0;
    start_s     = 1'b0;
    end_s       = 1'b0;
    ok_s        = 1'b0;
    drop_s      = 1'b0;
    retry_s     = retry_r;
    fid_s       = fid_r;
    buf_we_s    = 1'b0;
    lfsr_step_s = 1'b0;
    lfsr_load_s = 1'b0;
    if (bus.init_tab) begin
      idx_s       = FIRST_IDX;
      sym_s       = {SYM_W{1'b0}};
      retry_s     = {RC_W{1'b0}};
      fid_s       = {FID_W{1'b0}};
      lfsr_load_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_s = FIRST_IDX;
        end
        ST_SEND: begin
          if (bus.IsTransmit) begin
            sym_s       = lfsr_sym_s;
            valid_s     = 1'b1;
            start_s     = (idx_r == FIRST_IDX);
            end_s       = last_s;
            buf_we_s    = 1'b1;
            lfsr_step_s = 1'b1;
            idx_s       = last_s ? FIRST_IDX : idx_r + SECOND_IDX;
          end else begin
            idx_s = idx_r;
          end
        end
        ST_RESEND: begin
          if (bus.IsTransmit) begin
            sym_s   = frame_buf_r[idx_r];
            valid_s = 1'b1;
            start_s = (idx_r == FIRST_IDX);
            end_s   = last_s;
            idx_s   = last_s ? FIRST_IDX : idx_r + SECOND_IDX;
          end else begin
            idx_s = idx_r;
          end
        end
        ST_ACK: begin
          if (!bus.has_error) begin
            ok_s    = 1'b1;
            fid_s   = fid_r + FID_W'(1);
            retry_s = {RC_W{1'b0}};
            idx_s   = FIRST_IDX;
          end else if (can_retry_s) begin
            // Replay starts on the ACK edge itself so no extra bubble appears.
            retry_s = retry_r + RC_W'(1);
            sym_s   = frame_buf_r[FIRST_IDX];
            valid_s = 1'b1;
            start_s = 1'b1;
            idx_s   = SECOND_IDX;
          end else begin
            drop_s  = 1'b1;
            fid_s   = fid_r + FID_W'(1);
            retry_s = {RC_W{1'b0}};
            idx_s   = FIRST_IDX;
          end
        end
        default: begin
          idx_s = FIRST_IDX;
        end
      endcase
    end
  end

  // Registered outputs and symbol index.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      idx_r   <= FIRST_IDX;
      sym_r   <= {SYM_W{1'b0}};
      valid_r <= 1'b0;
      start_r <= 1'b0;
      end_r   <= 1'b0;
      ok_r    <= 1'b0;
      drop_r  <= 1'b0;
      retry_r <= {RC_W{1'b0}};
      fid_r   <= {FID_W{1'b0}};
    end else begin
      idx_r   <= idx_s;
      sym_r   <= sym_s;
      valid_r <= valid_s;
      start_r <= start_s;
      end_r   <= end_s;
      ok_r    <= ok_s;
      drop_r  <= drop_s;
      retry_r <= retry_s;
      fid_r   <= fid_s;
    end
  end

  // Frame buffer: captures each new-frame symbol at its index; contents need no reset.
  always_ff @(posedge sys_clk) begin
    if (buf_we_s) begin
      frame_buf_r[idx_r] <= lfsr_sym_s;
    end
  end

  assign bus.sym_out     = sym_r;
  assign bus.sym_valid   = valid_r;
  assign bus.frame_start = start_r;
  assign bus.frame_end   = end_r;
  assign bus.retry_cnt   = retry_r;
  assign bus.frame_id    = fid_r;
  assign bus.frame_ok    = ok_r;
  assign bus.frame_drop  = drop_r;

endmodule

// File: tb/tb_arq_symbol_tx.sv
// ---------------------------------------------------------------------------
// tb_arq_symbol_tx
// Self-checking bench for arq_symbol_tx: a default instance (2-bit symbols,
// 8-symbol frames, 3 retries) and a small one (4-bit symbols, 2-symbol
// frames, 1 retry). Expected symbols come from an LFSR sequence computed
// from the polynomial; random traffic is checked by a frame-level model.
// ---------------------------------------------------------------------------
module tb_arq_symbol_tx;

  localparam int SW   = 2;
  localparam int FL   = 8;
  localparam int MR   = 3;
  localparam int FW   = 8;
  localparam int RW   = 2;
  localparam int SW_B = 4;
  localparam int FL_B = 2;
  localparam int MR_B = 1;
  localparam int RW_B = 1;

  logic sys_clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 sys_clk = ~sys_clk;

  arq_symbol_tx_if #(.SYM_W(SW),   .FID_W(FW), .RC_W(RW))   bus_a ();
  arq_symbol_tx_if #(.SYM_W(SW_B), .FID_W(FW), .RC_W(RW_B)) bus_b ();

  arq_symbol_tx #(.SYM_W(SW), .FRAME_LEN(FL), .MAX_RETRY(MR), .SEED(16'hACE1), .FID_W(FW))
    dut_a (.sys_clk(sys_clk), .reset(reset), .bus(bus_a.master));
  arq_symbol_tx #(.SYM_W(SW_B), .FRAME_LEN(FL_B), .MAX_RETRY(MR_B), .SEED(16'hACE1), .FID_W(FW))
    dut_b (.sys_clk(sys_clk), .reset(reset), .bus(bus_b.master));

  // Reference symbol sequence straight from the polynomial.
  logic [15:0] lfsr_seq [4096];

  function automatic logic [15:0] spec_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [1:0] sa(input int k);
    return lfsr_seq[k][1:0];
  endfunction

  function automatic logic [3:0] sb(input int k);
    return lfsr_seq[k][3:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_init_a();
    bus_a.init_tab = 1'b1;
    tick();
    bus_a.init_tab = 1'b0;
  endtask

  function automatic logic [16:0] obs_a();
    return {bus_a.sym_valid, bus_a.frame_start, bus_a.frame_end, bus_a.frame_ok,
            bus_a.frame_drop, bus_a.retry_cnt, bus_a.frame_id,
            bus_a.sym_valid ? bus_a.sym_out : 2'b00};
  endfunction

  function automatic logic [17:0] obs_b();
    return {bus_b.sym_valid, bus_b.frame_start, bus_b.frame_end, bus_b.frame_ok,
            bus_b.frame_drop, bus_b.retry_cnt, bus_b.frame_id,
            bus_b.sym_valid ? bus_b.sym_out : 4'h0};
  endfunction

  typedef struct {
    logic       it;
    logic       he;
    logic       valid;
    logic [1:0] sym;
    logic       start;
    logic       fend;
    logic       ok;
    logic       drop;
    logic [1:0] retry;
    logic [7:0] fid;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic it, input logic he, input logic valid, input logic [1:0] sym,
                         input logic st, input logic fe, input logic ok, input logic dr,
                         input logic [1:0] rc, input logic [7:0] fid);
    vec_t v;
    v.it = it; v.he = he; v.valid = valid; v.sym = sym; v.start = st; v.fend = fe;
    v.ok = ok; v.drop = dr; v.retry = rc; v.fid = fid;
    vq.push_back(v);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lfsr_seq[0] = 16'hACE1;
    for (int k = 1; k < 4096; k++) lfsr_seq[k] = spec_step(lfsr_seq[k-1]);

    reset = 1'b0;
    bus_a.init_tab = 1'b0; bus_a.IsTransmit = 1'b0; bus_a.has_error = 1'b0;
    bus_b.init_tab = 1'b0; bus_b.IsTransmit = 1'b0; bus_b.has_error = 1'b0;
    tick();
    tick();
    check("reset_a", 64'(obs_a()), 64'd0);
    check("reset_b", 64'(obs_b()), 64'd0);
    reset = 1'b1;
    tick();
    check("post_reset_idle_a", 64'(obs_a()), 64'd0);

    // ---------------- table: clean frame, then one retried frame ----------------
    add_vec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] s;
      s = (i == 0) ? 2'b01 : ((i < 3) ? 2'b00 : sa(i));
      add_vec(1'b1, 1'b0, 1'b1, s, (i == 0), (i == 7), 1'b0, 1'b0, 2'd0, 8'd0);
    end
    add_vec(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);
    add_vec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
    for (int i = 0; i < 8; i++)
      add_vec(1'b1, 1'b1, 1'b1, sa(8 + i), (i == 0), (i == 7), 1'b0, 1'b0, 2'd0, 8'd1);
    add_vec(1'b0, 1'b1, 1'b1, sa(8), 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1);
    for (int i = 1; i < 8; i++)
      add_vec(1'b1, 1'b0, 1'b1, sa(8 + i), 1'b0, (i == 7), 1'b0, 1'b0, 2'd1, 8'd1);
    add_vec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd2);
    add_vec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    add_vec(1'b1, 1'b0, 1'b1, sa(16), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);

    for (int i = 0; i < vq.size(); i++) begin
      logic [16:0] exp_v;
      bus_a.IsTransmit = vq[i].it;
      bus_a.has_error  = vq[i].he;
      tick();
      exp_v = {vq[i].valid, vq[i].start, vq[i].fend, vq[i].ok, vq[i].drop, vq[i].retry,
               vq[i].fid, vq[i].valid ? vq[i].sym : 2'b00};
      check($sformatf("vec%0d", i), 64'(obs_a()), 64'(exp_v));
    end

    // ---------------- has_error held: 4 transmissions then drop ----------------
    begin
      int starts = 0, ends = 0, maxr = 0, pos = 0, oks = 0, mism = 0;
      bit dropped = 1'b0;
      bus_a.IsTransmit = 1'b0;
      do_init_a();
      bus_a.IsTransmit = 1'b1;
      bus_a.has_error  = 1'b1;
      for (int c = 0; c < 80 && !dropped; c++) begin
        tick();
        if (bus_a.frame_ok) oks++;
        if (bus_a.sym_valid) begin
          if (bus_a.frame_start) begin
            starts++;
            pos = 0;
          end
          if (pos < 8) begin
            if (bus_a.sym_out !== sa(pos)) mism++;
          end else begin
            mism++;
          end
          pos++;
          if (bus_a.frame_end) ends++;
          if (int'(bus_a.retry_cnt) > maxr) maxr = int'(bus_a.retry_cnt);
        end
        if (bus_a.frame_drop) begin
          dropped = 1'b1;
          check("drop_fid", 64'(bus_a.frame_id), 64'd1);
          check("drop_retry_clear", 64'(bus_a.retry_cnt), 64'd0);
        end
      end
      bus_a.IsTransmit = 1'b0;
      bus_a.has_error  = 1'b0;
      check("drop_seen", 64'(dropped), 64'd1);
      check("drop_tx_count", 64'(starts), 64'd4);
      check("drop_end_count", 64'(ends), 64'd4);
      check("drop_max_retry", 64'(maxr), 64'd3);
      check("drop_replay_syms", 64'(mism), 64'd0);
      check("drop_no_ok", 64'(oks), 64'd0);
      tick();
      check("drop_pulse_one_cycle", 64'({bus_a.frame_drop, bus_a.sym_valid}), 64'd0);
    end

    // ---------------- pauses at idx 4 (3 cycles) and on the last symbol ----------------
    begin
      int nv = 0, p1 = 0, p2 = 0;
      bit pz, got_end = 1'b0;
      bus_a.IsTransmit = 1'b1;
      tick();
      check("pause_entry", 64'(bus_a.sym_valid), 64'd0);
      for (int c = 0; c < 30 && !got_end; c++) begin
        if (nv == 4 && p1 < 3) begin
          bus_a.IsTransmit = 1'b0; p1++; pz = 1'b1;
        end else if (nv == 7 && p2 < 2) begin
          bus_a.IsTransmit = 1'b0; p2++; pz = 1'b1;
        end else begin
          bus_a.IsTransmit = 1'b1; pz = 1'b0;
        end
        tick();
        if (pz) begin
          check("pause_idle", 64'({bus_a.sym_valid, bus_a.frame_end}), 64'd0);
        end else begin
          check($sformatf("pause_sym%0d", nv),
                64'({bus_a.sym_valid, bus_a.sym_out, bus_a.frame_start, bus_a.frame_end}),
                64'({1'b1, sa(8 + nv), (nv == 0), (nv == 7)}));
          nv++;
          if (nv == 8) got_end = 1'b1;
        end
      end
      bus_a.IsTransmit = 1'b0;
      tick();
      check("pause_ok", 64'({bus_a.frame_ok, bus_a.frame_id, bus_a.sym_valid}), 64'({1'b1, 8'd2, 1'b0}));
      check("pause_count", 64'(nv), 64'd8);
    end

    // ---------------- init_tab in the middle of a replay ----------------
    bus_a.IsTransmit = 1'b1;
    bus_a.has_error  = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    check("rs_first_end", 64'({bus_a.sym_valid, bus_a.frame_end, bus_a.sym_out}), 64'({1'b1, 1'b1, sa(23)}));
    tick();
    check("rs_replay_start", 64'({bus_a.sym_valid, bus_a.frame_start, bus_a.retry_cnt, bus_a.sym_out}),
          64'({1'b1, 1'b1, 2'd1, sa(16)}));
    tick();
    tick();
    bus_a.init_tab = 1'b1;
    tick();
    check("init_clear", 64'(obs_a()), 64'd0);
    bus_a.init_tab   = 1'b0;
    bus_a.IsTransmit = 1'b0;
    bus_a.has_error  = 1'b0;
    tick();
    check("init_idle", 64'({bus_a.sym_valid, bus_a.frame_ok, bus_a.frame_drop}), 64'd0);
    bus_a.IsTransmit = 1'b1;
    tick();
    check("init_send_entry", 64'(bus_a.sym_valid), 64'd0);
    tick();
    check("init_restart", 64'({bus_a.sym_valid, bus_a.sym_out, bus_a.frame_start, bus_a.frame_id, bus_a.retry_cnt}),
          64'({1'b1, 2'b01, 1'b1, 8'd0, 2'd0}));
    bus_a.IsTransmit = 1'b0;

    // ---------------- small instance: 4-bit symbols, 2-symbol frames ----------------
    bus_b.IsTransmit = 1'b1;
    tick();
    check("b_entry", 64'(obs_b()), 64'd0);
    tick();
    check("b_sym0", 64'(obs_b()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h1}));
    tick();
    check("b_sym1", 64'(obs_b()), 64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, sb(1)}));
    bus_b.IsTransmit = 1'b0;
    tick();
    check("b_ack_ok", 64'(obs_b()), 64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 4'h0}));

    // ---------------- random traffic against a frame-level model ----------------
    begin
      int  base = 0, pos = 0, m_retry = 0, m_fid = 0, resolved = 0;
      bit  pend_ack = 1'b0;
      logic it_c, he_c;
      do_init_a();
      for (int c = 0; c < 3000; c++) begin
        it_c = ($urandom_range(0, 9) != 0);
        he_c = ($urandom_range(0, 9) < 4);
        bus_a.IsTransmit = it_c;
        bus_a.has_error  = he_c;
        tick();
        if (pend_ack) begin
          pend_ack = 1'b0;
          resolved++;
          if (!he_c) begin
            check("rnd_ack_ok", 64'({bus_a.frame_ok, bus_a.frame_drop, bus_a.sym_valid}), 64'({1'b1, 1'b0, 1'b0}));
            m_fid++; m_retry = 0; base += FL; pos = 0;
          end else if (m_retry < MR) begin
            check("rnd_ack_retry", 64'({bus_a.frame_ok, bus_a.frame_drop, bus_a.sym_valid}), 64'({1'b0, 1'b0, 1'b1}));
            m_retry++; pos = 0;
          end else begin
            check("rnd_ack_drop", 64'({bus_a.frame_ok, bus_a.frame_drop, bus_a.sym_valid}), 64'({1'b0, 1'b1, 1'b0}));
            m_fid++; m_retry = 0; base += FL; pos = 0;
          end
        end else begin
          check("rnd_no_pulse", 64'({bus_a.frame_ok, bus_a.frame_drop}), 64'd0);
          if (!it_c) check("rnd_paused", 64'(bus_a.sym_valid), 64'd0);
        end
        if (bus_a.sym_valid) begin
          if (pos >= FL) begin
            check("rnd_frame_overrun", 64'(pos), 64'(FL - 1));
          end else begin
            check($sformatf("rnd_sym_c%0d", c),
                  64'({bus_a.sym_out, bus_a.frame_start, bus_a.frame_end, bus_a.retry_cnt, bus_a.frame_id}),
                  64'({sa(base + pos), (pos == 0), (pos == FL - 1), 2'(m_retry), 8'(m_fid)}));
            if (pos == FL - 1) pend_ack = 1'b1;
            pos++;
          end
        end
      end
      check("rnd_progress", 64'(resolved > 50), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
